adapter_seq_low_res: RTL and testbench
======================================

# adapter_seq_low_res

Sequencing adapter between the top-level start/mode/done control and the low-resource Dilithium core's 4-bit opcode port. It expands one `start` into the full opcode sequence for keygen, sign or verify, issuing each opcode on a valid/ready handshake. It supports a programmable number of message-digest chunks and flags an illegal mode. An optional watchdog aborts a stalled core.

## Interface
Parameters:
- `OP_W`, 4: opcode width.
- `CHUNK_W`, 16: width of the message-chunk count.
- `TIMEOUT_CYCLES`, 1048576: stall limit. Used only with the watchdog compiled in.

Ports (one clock `clk`; reset `rst` is asynchronous and active-high):
- `clk`, in, 1: clock.
- `rst`, in, 1: async active-high reset.
- `start`, in, 1: request an operation. Sampled only in IDLE.
- `mode`, in, 2: operation select, sampled with `start`. 0 = keygen, 1 = verify, 2 = sign, 3 = illegal.
- `msg_chunks`, in, CHUNK_W: number of DIGEST_MSG ops, sampled with `start`. A value of 0 is treated as 1.
- `done`, out, 1: one-cycle completion pulse.
- `err`, out, 1: error flag for the last operation. Held until the next accepted `start`.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `op_in`, out, OP_W: opcode to the core.
- `op_valid_in`, out, 1: opcode valid.
- `ready_out`, in, 1: core ready; accepts the presented opcode.

## Operation
Opcodes:
- STOR = {2'b11, type}; LOAD = {2'b10, type}.
- Payload types: PK = 00, SK = 01, SIG = 10, SEED = 11.
- DIGEST = 0001, SIGN = 0010, VRFY = 0100, KGEN = 0111.

Sequences (N = max(msg_chunks, 1)):
- Keygen: STOR SEED, KGEN, LOAD SK, LOAD PK. `msg_chunks` is ignored.
- Sign: STOR SK, DIGEST ×N, SIGN, LOAD SIG.
- Verify: STOR PK, STOR SIG, DIGEST ×N, VRFY.

FSM states:
- IDLE:
  - `start` with a legal mode: latch mode and N, clear `err`, load the first opcode, go to ISSUE.
  - `start` with mode 3: set `err`, pulse `done`, stay in IDLE.
- ISSUE: `op_valid_in` = 1. On the handshake (`op_valid_in && ready_out`):
  - not the last op: load the next opcode and stay in ISSUE;
  - last op: go to WAIT_DONE.
  - The DIGEST step repeats until the chunk counter reaches N.
- WAIT_DONE: `op_valid_in` = 0. When `ready_out` = 1, pulse `done` and return to IDLE.

Handshake and state rules:
- `start` while busy is ignored.
- Step index (0..3) and chunk counter (CHUNK_W) both reset on each accepted `start`.
- An opcode is held stable while `op_valid_in` = 1 and `ready_out` = 0.

## Timing
- All outputs are registered.
- Reset values: `op_in` = 0, `op_valid_in` = 0, `done` = 0, `err` = 0, `busy` = 0, state IDLE, counters 0.
- Async reset mid-operation clears everything immediately. The core is not notified; the integrator resets it alongside.
- `start` at cycle t produces the first opcode with `op_valid_in` = 1 at t+1.
- Back-to-back acceptance is allowed: with `ready_out` held high, one opcode is issued per cycle.
- WAIT_DONE is entered on the cycle after the last acceptance. `ready_out` = 1 there at cycle w gives `done` = 1 at w+1 only.
- Illegal mode: `start` at t gives `done` = `err` = 1 at t+1, and no opcode is issued.
- Keygen with `ready_out` constantly 1: opcodes at t+1..t+4, `done` at t+6, `busy` high t+1..t+5.

## Configuration
Macro: `ADAPTER_SEQ_TIMEOUT_EN`.

Defined:
- A stall counter increments each cycle in ISSUE/WAIT_DONE with `ready_out` = 0.
- The counter clears on `ready_out` = 1 or on any state change.
- When the counter = TIMEOUT_CYCLES−1 and `ready_out` = 0: next cycle `done` = `err` = 1, `op_valid_in` = 0, state IDLE.

Undefined:
- No counter is synthesised and `TIMEOUT_CYCLES` is unused.
- The adapter waits indefinitely.
- `err` is set only for illegal mode.

## Structure
- Package `adapter_pkg` holds:
  - opcode and payload-type localparams;
  - mode encodings;
  - the `state_t` enum (IDLE, ISSUE, WAIT_DONE).
- Sub-module `adapter_seq_rom` is combinational:
  - inputs: mode, step index;
  - outputs: opcode, `is_digest`, `is_last`.
- The top level holds the FSM, step and chunk counters, output registers and the optional watchdog.

## Test plan
- Keygen, `ready_out` = 1 throughout, `start` at t:
  - opcodes 1111, 0111, 1001, 1000 at t+1..t+4;
  - `done` pulse at t+6, `err` = 0.
- Sign, `msg_chunks` = 3, `ready_out` toggling every cycle, extra `start` pulses while busy:
  - opcodes 1101, 0001, 0001, 0001, 0010, 1010, each held stable until accepted;
  - extra starts ignored;
  - a single `done`.
- Verify, `msg_chunks` = 0: opcodes 1100, 1110, 0001, 0100; `done` after `ready_out` returns high in WAIT_DONE.
- Mode 3, `start` at t: `done` = `err` = 1 at t+1, `op_valid_in` never asserts; the next legal `start` clears `err`.
- With `ADAPTER_SEQ_TIMEOUT_EN`, TIMEOUT_CYCLES = 16, keygen started at t, `ready_out` = 0 throughout:
  - `op_valid_in` holds 1111 from t+1 to t+16;
  - `done` = `err` = 1 at t+17, `busy` = 0 after.
- Sign under way, assert `rst` asynchronously between edges:
  - all outputs drop to 0 immediately;
  - after release, a keygen `start` completes normally.

Source files
------------

// File: rtl/adapter_pkg.sv
// Shared encodings for the Dilithium low-resource sequencing adapter:
// opcodes, payload types, operation modes and FSM states.
package adapter_pkg;

  localparam logic [1:0] PT_PK   = 2'b00;
  localparam logic [1:0] PT_SK   = 2'b01;
  localparam logic [1:0] PT_SIG  = 2'b10;
  localparam logic [1:0] PT_SEED = 2'b11;

  localparam logic [1:0] OP_STOR_PFX = 2'b11;
  localparam logic [1:0] OP_LOAD_PFX = 2'b10;

  localparam logic [3:0] OP_DIGEST = 4'b0001;
  localparam logic [3:0] OP_SIGN   = 4'b0010;
  localparam logic [3:0] OP_VRFY   = 4'b0100;
  localparam logic [3:0] OP_KGEN   = 4'b0111;

  localparam logic [1:0] MODE_KEYGEN  = 2'd0;
  localparam logic [1:0] MODE_VERIFY  = 2'd1;
  localparam logic [1:0] MODE_SIGN    = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  function automatic logic [3:0] stor_op(input logic [1:0] pt);
    return {OP_STOR_PFX, pt};
  endfunction

  function automatic logic [3:0] load_op(input logic [1:0] pt);
    return {OP_LOAD_PFX, pt};
  endfunction

endpackage

// File: rtl/adapter_seq_rom.sv
// Combinational opcode table: maps (mode, step) to the opcode plus flags
// marking the repeatable DIGEST step and the final step of the sequence.
module adapter_seq_rom
  import adapter_pkg::*;
(
  input  logic [1:0] mode_i,
  input  logic [1:0] step_i,
  output logic [3:0] op_o,
  output logic       is_digest_o,
  output logic       is_last_o
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    op_o        = 4'b0000;
    is_digest_o = 1'b0;
    is_last_o   = (step_i == 2'd3);
    case (mode_i)
      MODE_KEYGEN: begin
        case (step_i)
          2'd0:    op_o = stor_op(PT_SEED);
          2'd1:    op_o = OP_KGEN;
          2'd2:    op_o = load_op(PT_SK);
          default: op_o = load_op(PT_PK);
        endcase
      end
      MODE_SIGN: begin
        case (step_i)
          2'd0:    op_o = stor_op(PT_SK);
          2'd1:    op_o = OP_DIGEST;
          2'd2:    op_o = OP_SIGN;
          default: op_o = load_op(PT_SIG);
        endcase
        is_digest_o = (step_i == 2'd1);
      end
      MODE_VERIFY: begin
        case (step_i)
          2'd0:    op_o = stor_op(PT_PK);
          2'd1:    op_o = stor_op(PT_SIG);
          2'd2:    op_o = OP_DIGEST;
          default: op_o = OP_VRFY;
        endcase
        is_digest_o = (step_i == 2'd2);
      end
      default: is_last_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/adapter_seq_low_res.sv
// Expands start/mode into the core's opcode sequence over a valid/ready
// handshake. Define ADAPTER_SEQ_TIMEOUT_EN to compile in the stall watchdog.
module adapter_seq_low_res
  import adapter_pkg::*;
#(
  parameter int          OP_W           = 4,
  parameter int          CHUNK_W        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [CHUNK_W-1:0] msg_chunks,
  output logic               done,
  output logic               err,
  output logic               busy,
  output logic [OP_W-1:0]    op_in,
  output logic               op_valid_in,
  input  logic               ready_out
);

  state_t             state_q, state_d;
  logic [1:0]         step_q, step_d;
  logic [1:0]         mode_q, mode_d;
  logic [CHUNK_W-1:0] chunk_q, chunk_d;
  logic [CHUNK_W-1:0] n_q, n_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic               digest_q, digest_d;
  logic               last_q, last_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  // The table is addressed with the step about to be loaded, so the
  // opcode and its flags are registered together.
  logic [1:0] rom_mode, rom_step;
  logic [3:0] rom_op;
  logic       rom_digest, rom_last;

  assign rom_mode = (state_q == IDLE) ? mode : mode_q;
  assign rom_step = (state_q == IDLE) ? 2'd0 : step_q + 2'd1;

  adapter_seq_rom u_rom (
    .mode_i      (rom_mode),
    .step_i      (rom_step),
    .op_o        (rom_op),
    .is_digest_o (rom_digest),
    .is_last_o   (rom_last)
  );

`ifdef ADAPTER_SEQ_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               timeout;
  assign timeout = (state_q != IDLE) && !ready_out &&
                   (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    mode_d   = mode_q;
    chunk_d  = chunk_q;
    n_d      = n_q;
    op_d     = op_q;
    digest_d = digest_q;
    last_d   = last_q;
    valid_d  = valid_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (mode == MODE_ILLEGAL) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            mode_d   = mode;
            n_d      = (msg_chunks == '0) ? CHUNK_W'(1) : msg_chunks;
            err_d    = 1'b0;
            step_d   = 2'd0;
            chunk_d  = '0;
            op_d     = OP_W'(rom_op);
            digest_d = rom_digest;
            last_d   = rom_last;
            valid_d  = 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (valid_q && ready_out) begin
          if (digest_q && (chunk_q + CHUNK_W'(1) != n_q)) begin
            chunk_d = chunk_q + CHUNK_W'(1);
          end else if (last_q) begin
            valid_d = 1'b0;
            state_d = WAIT_DONE;
          end else begin
            step_d   = step_q + 2'd1;
            op_d     = OP_W'(rom_op);
            digest_d = rom_digest;
            last_d   = rom_last;
          end
        end
      end
      WAIT_DONE: begin
        if (ready_out) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef ADAPTER_SEQ_TIMEOUT_EN
    if (timeout) begin
      state_d = IDLE;
      valid_d = 1'b0;
      done_d  = 1'b1;
      err_d   = 1'b1;
    end
    stall_d = ((state_q != IDLE) && !ready_out && (state_d == state_q))
              ? stall_q + STALL_W'(1) : '0;
`endif

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      step_q   <= '0;
      mode_q   <= '0;
      chunk_q  <= '0;
      n_q      <= '0;
      op_q     <= '0;
      digest_q <= 1'b0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      mode_q   <= mode_d;
      chunk_q  <= chunk_d;
      n_q      <= n_d;
      op_q     <= op_d;
      digest_q <= digest_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

`ifdef ADAPTER_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end
`endif

  assign op_in       = op_q;
  assign op_valid_in = valid_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_adapter_seq_low_res.sv
// Scoreboard bench for adapter_seq_low_res: stimulus queues expected opcodes
// and done/err results, a negedge monitor compares them as the DUT presents them.
module tb_adapter_seq_low_res;

  localparam int          OP_W    = 4;
  localparam int          CHUNK_W = 16;
  localparam int unsigned TO      = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [1:0]         mode = 2'd0;
  logic [CHUNK_W-1:0] msg_chunks = '0;
  logic               ready_out = 1'b0;
  logic               done, err, busy, op_valid_in;
  logic [OP_W-1:0]    op_in;

  adapter_seq_low_res #(
    .OP_W           (OP_W),
    .CHUNK_W        (CHUNK_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .msg_chunks  (msg_chunks),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .op_in       (op_in),
    .op_valid_in (op_valid_in),
    .ready_out   (ready_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Scoreboard
  logic [3:0] exp_ops[$];
  bit         exp_err[$];
  int         done_cnt = 0;
  int         acc_cnt  = 0;
  logic       hold_pend = 1'b0;
  logic [3:0] hold_op   = '0;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && !done) begin
        check("hold_valid", 32'(op_valid_in), 32'd1);
        check("hold_op", 32'(op_in), 32'(hold_op));
      end
      hold_pend = op_valid_in && !ready_out;
      hold_op   = op_in;
      if (op_valid_in && ready_out) begin
        acc_cnt++;
        if (exp_ops.size() == 0) fail($sformatf("unexpected_op %04b", op_in));
        else check("op", 32'(op_in), 32'(exp_ops.pop_front()));
      end
      if (done) begin
        done_cnt++;
        if (exp_err.size() == 0) fail("unexpected_done");
        else check("done_err", 32'(err), 32'(exp_err.pop_front()));
      end
    end
  end

  logic tog_en = 1'b0;
  always @(posedge clk) begin
    if (tog_en) begin
      #1 ready_out = ~ready_out;
    end
  end

  // Called #1 after a posedge; start is high during cycle t, returns at t+1 (+#1).
  task automatic issue(input logic [1:0] m, input logic [CHUNK_W-1:0] n, output int t);
    mode       = m;
    msg_chunks = n;
    start      = 1'b1;
    t          = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int old, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > old) return;
    end
    fail("done_timeout");
  endtask

  task automatic push_keygen();
    exp_ops.push_back(4'b1111);
    exp_ops.push_back(4'b0111);
    exp_ops.push_back(4'b1001);
    exp_ops.push_back(4'b1000);
    exp_err.push_back(1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_op"},    32'(op_in),       32'd0);
    check({tag, "_valid"}, 32'(op_valid_in), 32'd0);
    check({tag, "_done"},  32'(done),        32'd0);
    check({tag, "_err"},   32'(err),         32'd0);
    check({tag, "_busy"},  32'(busy),        32'd0);
  endtask

  initial begin
    int t, base, acc0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Keygen, ready always high: ops t+1..t+4, busy t+1..t+5, done t+6
    ready_out = 1'b1;
    push_keygen();
    base = done_cnt;
    issue(2'd0, 16'd5, t);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("kg_busy_t%0d", k), 32'(busy), 32'(k <= 5));
      check($sformatf("kg_done_t%0d", k), 32'(done), 32'(k == 6));
      if (k <= 4) check($sformatf("kg_valid_t%0d", k), 32'(op_valid_in), 32'd1);
    end
    check("kg_err", 32'(err), 32'd0);
    check("kg_done_count", 32'(done_cnt - base), 32'd1);
    check("kg_ops_left", 32'(exp_ops.size()), 32'd0);

    // Sign, 3 chunks, ready toggling, ignored starts while busy
    @(posedge clk);
    #1 ready_out = 1'b0;
    exp_ops.push_back(4'b1101);
    repeat (3) exp_ops.push_back(4'b0001);
    exp_ops.push_back(4'b0010);
    exp_ops.push_back(4'b1010);
    exp_err.push_back(1'b0);
    base   = done_cnt;
    tog_en = 1'b1;
    issue(2'd2, 16'd3, t);
    for (int j = 0; j < 3; j++) begin
      repeat (2) @(posedge clk);
      #1;
      mode  = 2'd0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    wait_done(base, 60);
    repeat (4) @(negedge clk);
    tog_en = 1'b0;
    check("sg_done_count", 32'(done_cnt - base), 32'd1);
    check("sg_ops_left", 32'(exp_ops.size()), 32'd0);
    check("sg_busy_after", 32'(busy), 32'd0);

    // Verify, msg_chunks = 0, ready low in WAIT_DONE
    @(posedge clk);
    #1 ready_out = 1'b1;
    exp_ops.push_back(4'b1100);
    exp_ops.push_back(4'b1110);
    exp_ops.push_back(4'b0001);
    exp_ops.push_back(4'b0100);
    exp_err.push_back(1'b0);
    base = done_cnt;
    issue(2'd1, 16'd0, t);
    repeat (4) @(posedge clk);
    #1 ready_out = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("vf_wait_done", 32'(done), 32'd0);
      check("vf_wait_busy", 32'(busy), 32'd1);
      check("vf_wait_valid", 32'(op_valid_in), 32'd0);
    end
    @(posedge clk);
    #1 ready_out = 1'b1;
    @(negedge clk);
    check("vf_done_w", 32'(done), 32'd0);
    @(negedge clk);
    check("vf_done_w1", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    check("vf_done_count", 32'(done_cnt - base), 32'd1);
    check("vf_ops_left", 32'(exp_ops.size()), 32'd0);

    // Illegal mode: done = err = 1 at t+1, no opcode
    exp_err.push_back(1'b1);
    acc0 = acc_cnt;
    issue(2'd3, 16'd0, t);
    @(negedge clk);
    check("il_done", 32'(done), 32'd1);
    check("il_err", 32'(err), 32'd1);
    check("il_busy", 32'(busy), 32'd0);
    check("il_valid", 32'(op_valid_in), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("il_err_held", 32'(err), 32'd1);
      check("il_no_valid", 32'(op_valid_in), 32'd0);
    end
    check("il_no_accept", 32'(acc_cnt - acc0), 32'd0);
    @(posedge clk);
    #1;
    push_keygen();
    base = done_cnt;
    issue(2'd0, 16'd0, t);
    @(negedge clk);
    check("il_err_cleared", 32'(err), 32'd0);
    wait_done(base, 20);

    // Async reset during sign
    @(posedge clk);
    #1 ready_out = 1'b0;
    issue(2'd2, 16'd2, t);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_all_zero("arst");
    exp_ops.delete();
    exp_err.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 ready_out = 1'b1;
    push_keygen();
    base = done_cnt;
    issue(2'd0, 16'd0, t);
    wait_done(base, 20);
    check("arst_ops_left", 32'(exp_ops.size()), 32'd0);

`ifdef ADAPTER_SEQ_TIMEOUT_EN
    // Watchdog: keygen with ready low throughout
    @(posedge clk);
    #1 ready_out = 1'b0;
    exp_err.push_back(1'b1);
    issue(2'd0, 16'd0, t);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("wd_valid_t%0d", k), 32'(op_valid_in), 32'd1);
      check($sformatf("wd_op_t%0d", k), 32'(op_in), 32'b1111);
    end
    @(negedge clk);
    check("wd_done", 32'(done), 32'd1);
    check("wd_err", 32'(err), 32'd1);
    check("wd_valid_off", 32'(op_valid_in), 32'd0);
    @(negedge clk);
    check("wd_busy_after", 32'(busy), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("final_err_queue", 32'(exp_err.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
